syscon_rx: RTL and testbench

Receive-side counterpart of the system-control pin pair: sits in a downstream device clocked by its own local `clk`. It takes the externally driven `clk_pin` (half-rate toggle) and `rst_pin` (active-high reset) and synchronizes both. It checks that `clk_pin` toggles at the expected rate and produces a clean, locally synchronous reset that is held until the link is locked and the remote reset has been released.

---
 rtl/syscon_pkg.sv | 13 +
 rtl/syscon_sync.sv | 28 ++
 rtl/syscon_rx.sv | 156 +++++++++++++++
 tb/tb_syscon_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/syscon_pkg.sv
// Shared types and constants for the system-control receive path.
package syscon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage

// File: rtl/syscon_sync.sv
// N-flop synchronizer for one asynchronous pin, with a selectable reset value.
module syscon_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the pin into the bottom of the chain.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {STAGES{RST_VAL}};
    else        chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/syscon_rx.sv
// Receive side of the system-control pin pair: pin synchronization, toggle-rate
// lock checking, fault counting and a stretched local reset.
module syscon_rx
  import syscon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EXPECT_HALF = 1,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_EDGES  = 4,
  parameter int unsigned RST_STRETCH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_pin,
  input  logic                 rst_pin,
  output logic                 rst_out,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned HALF_W  = $clog2(EXPECT_HALF + TOL + 2);
  localparam int unsigned GOOD_W  = $clog2(LOCK_EDGES + 1);
  localparam int unsigned STR_W   = (RST_STRETCH > 0) ? $clog2(RST_STRETCH + 1) : 1;
  localparam int unsigned WIN_LO_I = (EXPECT_HALF > TOL) ? (EXPECT_HALF - TOL) : 0;

  localparam logic [HALF_W-1:0] LIMIT  = HALF_W'(EXPECT_HALF + TOL + 1);
  localparam logic [HALF_W-1:0] WIN_LO = HALF_W'(WIN_LO_I);
  localparam logic [HALF_W-1:0] WIN_HI = HALF_W'(EXPECT_HALF + TOL);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_EDGES);
  localparam logic [STR_W-1:0]  STR_LAST    = STR_W'(RST_STRETCH - 1);
  localparam logic [STR_W-1:0]  STR_FULL    = STR_W'(RST_STRETCH);

  logic clk_sync;
  logic rst_sync;
  logic tog;
  logic half_good;
  logic half_timeout;
  logic fault;

  lock_state_e          state_q,     state_d;
  logic                 clk_prev_q,  clk_prev_d;
  logic [HALF_W-1:0]    half_cnt_q,  half_cnt_d;
  logic [GOOD_W-1:0]    good_cnt_q,  good_cnt_d;
  logic [STR_W-1:0]     str_cnt_q,   str_cnt_d;
  logic                 locked_q,    locked_d;
  logic                 err_q,       err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 rst_out_q,   rst_out_d;

  syscon_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (clk_pin),
    .q     (clk_sync)
  );

  syscon_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rst_pin),
    .q     (rst_sync)
  );

  assign tog          = clk_sync ^ clk_prev_q;
  assign half_good    = (half_cnt_q >= WIN_LO) && (half_cnt_q <= WIN_HI);
  assign half_timeout = (half_cnt_q == LIMIT);

  // Half-period measurement, lock state machine and fault accounting.
  always_comb begin
    state_d     = state_q;
    clk_prev_d  = clk_sync;
    half_cnt_d  = half_cnt_q;
    good_cnt_d  = good_cnt_q;
    err_count_d = err_count_q;
    fault       = 1'b0;

    if (tog)                      half_cnt_d = HALF_W'(1);
    else if (half_cnt_q != LIMIT) half_cnt_d = half_cnt_q + HALF_W'(1);

    unique case (state_q)
      UNLOCKED: begin
        // First edge only arms the measurement; its half-period is unknown.
        if (tog) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ACQUIRE: begin
        if (tog && half_good) begin
          good_cnt_d = good_cnt_q + GOOD_W'(1);
          if (good_cnt_d == GOOD_TARGET) state_d = LOCKED;
        end else if (tog || half_timeout) begin
          state_d = UNLOCKED;
          fault   = 1'b1;
        end
      end
      LOCKED: begin
        if ((tog && !half_good) || (!tog && half_timeout)) begin
          state_d = UNLOCKED;
          fault   = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase

    if (fault && (err_count_q != ERR_CNT_MAX)) err_count_d = err_count_q + ERR_CNT_W'(1);
    err_d    = fault;
    locked_d = (state_d == LOCKED);
  end

  // Local reset: asserted immediately on a violation, released after a clean stretch.
  always_comb begin
    str_cnt_d = str_cnt_q;
    rst_out_d = 1'b1;
    if (rst_sync || !locked_q) begin
      str_cnt_d = '0;
    end else if (str_cnt_q >= STR_LAST) begin
      str_cnt_d = STR_FULL;
      rst_out_d = 1'b0;
    end else begin
      str_cnt_d = str_cnt_q + STR_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      clk_prev_q  <= 1'b0;
      half_cnt_q  <= '0;
      good_cnt_q  <= '0;
      str_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      rst_out_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_prev_q  <= clk_prev_d;
      half_cnt_q  <= half_cnt_d;
      good_cnt_q  <= good_cnt_d;
      str_cnt_q   <= str_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      rst_out_q   <= rst_out_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_syscon_rx.sv
// Directed bench for syscon_rx with default parameters.
module tb_syscon_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_pin;
  logic       rst_pin;
  logic       rst_out;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;

  // Background remote-clock driver: toggles clk_pin every pin_div local cycles.
  bit pin_run = 1'b0;
  int pin_div = 1;
  int pin_ctr = 0;
  int err_pulses = 0;

  syscon_rx dut (
    .clk       (clk),
    .rst       (rst),
    .clk_pin   (clk_pin),
    .rst_pin   (rst_pin),
    .rst_out   (rst_out),
    .locked    (locked),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (pin_run) begin
      pin_ctr++;
      if (pin_ctr >= pin_div) begin
        pin_ctr = 0;
        clk_pin = ~clk_pin;
      end
    end else begin
      pin_ctr = 0;
    end
  end

  always @(negedge clk) begin
    if (err === 1'b1) err_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst_pin = 1'b0; clk_pin = 1'b0; pin_run = 1'b0;
    repeat (3) step();
    tests++; if (rst_out !== 1'b1) begin fails++; $display("FAIL reset_rst_out: got %b want 1", rst_out); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    rst = 1'b1;
    repeat (4) step();
    tests++; if (rst_out !== 1'b1) begin fails++; $display("FAIL idle_rst_out: got %b want 1", rst_out); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL idle_locked: got %b want 0", locked); end
  endtask

  // Start toggling every cycle; first pin change lands just after edge 1.
  task automatic test_nominal_lock(input string tag);
    int lock_at = -1;
    int rel_at  = -1;
    int e0      = err_pulses;
    pin_div = 1;
    pin_run = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (locked === 1'b1 && lock_at < 0) lock_at = n;
      if (rst_out === 1'b0 && rel_at < 0) rel_at = n;
    end
    tests++; if (lock_at != 8) begin fails++; $display("FAIL %s_lock_cycle: got %0d want 8", tag, lock_at); end
    tests++; if (rel_at != 11) begin fails++; $display("FAIL %s_release_cycle: got %0d want 11", tag, rel_at); end
    tests++; if (err_pulses - e0 != 0) begin fails++; $display("FAIL %s_no_err: got %0d pulses want 0", tag, err_pulses - e0); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL %s_err_count: got %0d want 0", tag, err_count); end
  endtask

  task automatic test_remote_reset();
    logic r2, r3, r9, r10;
    bit   lock_drop = 1'b0;
    int   e0 = err_pulses;
    rst_pin = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 5) rst_pin = 1'b0;
      if (k == 2) r2 = rst_out;
      if (k == 3) r3 = rst_out;
      if (k == 9) r9 = rst_out;
      if (k == 10) r10 = rst_out;
      if (locked !== 1'b1) lock_drop = 1'b1;
    end
    tests++; if (r2 !== 1'b0) begin fails++; $display("FAIL remote_rst_out_k2: got %b want 0", r2); end
    tests++; if (r3 !== 1'b1) begin fails++; $display("FAIL remote_rst_out_k3: got %b want 1", r3); end
    tests++; if (r9 !== 1'b1) begin fails++; $display("FAIL remote_rst_out_k9: got %b want 1", r9); end
    tests++; if (r10 !== 1'b0) begin fails++; $display("FAIL remote_rst_out_k10: got %b want 0", r10); end
    tests++; if (lock_drop !== 1'b0) begin fails++; $display("FAIL remote_locked_held: got drop=%b want 0", lock_drop); end
    tests++; if (err_pulses - e0 != 0) begin fails++; $display("FAIL remote_no_err: got %0d pulses want 0", err_pulses - e0); end
  endtask

  task automatic test_clock_stop();
    logic e4, e5, e6, l4, l5, r5, r6;
    logic [7:0] c5, c10;
    pin_run = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 4) begin e4 = err; l4 = locked; end
      if (k == 5) begin e5 = err; l5 = locked; r5 = rst_out; c5 = err_count; end
      if (k == 6) begin e6 = err; r6 = rst_out; end
      if (k == 10) c10 = err_count;
    end
    tests++; if (e4 !== 1'b0 || l4 !== 1'b1) begin fails++; $display("FAIL stop_k4: got err=%b locked=%b want 0/1", e4, l4); end
    tests++; if (e5 !== 1'b1) begin fails++; $display("FAIL stop_err_pulse: got %b want 1", e5); end
    tests++; if (l5 !== 1'b0) begin fails++; $display("FAIL stop_locked: got %b want 0", l5); end
    tests++; if (r5 !== 1'b0) begin fails++; $display("FAIL stop_rst_out_k5: got %b want 0", r5); end
    tests++; if (e6 !== 1'b0) begin fails++; $display("FAIL stop_err_single: got %b want 0", e6); end
    tests++; if (r6 !== 1'b1) begin fails++; $display("FAIL stop_rst_out_k6: got %b want 1", r6); end
    tests++; if (c5 !== 8'd1) begin fails++; $display("FAIL stop_err_count: got %0d want 1", c5); end
    tests++; if (c10 !== 8'd1) begin fails++; $display("FAIL stop_no_refire: got %0d want 1", c10); end
  endtask

  // Toggle every 2 cycles: every arm is followed by a bad edge, one fault per 4 cycles.
  task automatic test_wrong_rate();
    int e0 = err_pulses;
    bit saw_lock = 1'b0;
    pin_div = 2;
    pin_run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (locked !== 1'b0) saw_lock = 1'b1;
    end
    tests++; if (saw_lock !== 1'b0) begin fails++; $display("FAIL wrong_never_lock: got saw_lock=%b want 0", saw_lock); end
    tests++; if (err_pulses - e0 != 9) begin fails++; $display("FAIL wrong_err_pulses: got %0d want 9", err_pulses - e0); end
    tests++; if (err_count !== 8'd10) begin fails++; $display("FAIL wrong_err_count: got %0d want 10", err_count); end
  endtask

  task automatic test_saturation();
    int e1;
    repeat (1100) step();
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
    e1 = err_pulses;
    repeat (20) step();
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d want 255", err_count); end
    tests++; if (err_pulses - e1 != 5) begin fails++; $display("FAIL sat_err_pulses: got %0d want 5", err_pulses - e1); end
  endtask

  task automatic test_async_reset();
    bit got_lock = 1'b0;
    pin_div = 1;
    for (int k = 1; k <= 40 && !got_lock; k++) begin
      step();
      if (locked === 1'b1) got_lock = 1'b1;
    end
    tests++; if (got_lock !== 1'b1) begin fails++; $display("FAIL async_prelock: got %b want 1", got_lock); end
    step();
    rst = 1'b0;
    #1;
    tests++; if (rst_out !== 1'b1) begin fails++; $display("FAIL async_rst_out: got %b want 1", rst_out); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL async_locked: got %b want 0", locked); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL async_err: got %b want 0", err); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL async_err_count: got %0d want 0", err_count); end
    pin_run = 1'b0;
    clk_pin = 1'b0;
    #3;
    rst = 1'b1;
    repeat (4) step();
    tests++; if (locked !== 1'b0 || rst_out !== 1'b1) begin fails++; $display("FAIL async_idle: got locked=%b rst_out=%b want 0/1", locked, rst_out); end
    test_nominal_lock("relock");
  endtask

  initial begin
    test_reset();
    test_nominal_lock("nominal");
    test_remote_reset();
    test_clock_stop();
    test_wrong_rate();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
